// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one 32-bit ALU.
// Results are held in a one-deep registered output stage with ready/valid handshake.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_f,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_z,
  output logic               rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic             last_grant;
  logic             accept_en;
  logic             accept;
  logic             winner;
  logic [2:0]       op_f;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] b_mux;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu_y;

  // Accept when the output slot is free or being drained this cycle; ties go to the other requester.
  always_comb begin
    accept_en = rst_n && ((state == EMPTY) || rsp_ready);
    accept    = accept_en && (req_valid != 2'b00);
    winner    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    req_ready = 2'b00;
    if (accept) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  // Shared ALU: f[2] inverts B and supplies the carry-in, f[1:0] picks the function.
  always_comb begin
    op_f  = winner ? req_f[5:3] : req_f[2:0];
    op_a  = winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    op_b  = winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    b_mux = op_f[2] ? ~op_b : op_b;
    sum   = op_a + b_mux + WIDTH'(op_f[2]);
    alu_y = '0;
    case (op_f[1:0])
      2'b00:   alu_y = op_a & b_mux;
      2'b01:   alu_y = op_a | b_mux;
      2'b10:   alu_y = sum;
      default: alu_y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_y      <= '0;
      rsp_z      <= 1'b0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      state      <= FULL;
      rsp_y      <= alu_y;
      rsp_z      <= (alu_y == '0);
      rsp_id     <= winner;
      last_grant <= winner;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_f;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_y;
  logic        rsp_z;
  logic        rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_f(req_f), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd4:    return a & ~b;
      3'd5:    return a | ~b;
      3'd6:    return d;
      3'd7:    return (d >> 31);
      default: return 32'd0;
    endcase
  endfunction

  // Transaction-level model: one held result slot plus the last winner.
  logic        m_known = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_y     = '0;
  logic        m_ychk  = 1'b0;
  logic        m_id    = 1'b0;
  logic        m_last  = 1'b1;

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    logic       w;
    logic [2:0] f;
    e_rdy = 2'b00;
    w     = (req_valid == 2'b11) ? !m_last : req_valid[1];
    if (rst_n && (!m_valid || rsp_ready) && req_valid != 2'b00)
      e_rdy = w ? 2'b10 : 2'b01;
    if (m_known) begin
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        if (m_ychk) begin
          chk("rsp_y", rsp_y, m_y);
          chk("rsp_z", 32'(rsp_z), 32'(m_y == 32'd0));
        end
      end
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_y     = '0;
      m_ychk  = 1'b1;
      m_id    = 1'b0;
      m_last  = 1'b1;
    end else if (e_rdy != 2'b00) begin
      f       = w ? req_f[5:3] : req_f[2:0];
      m_valid = 1'b1;
      m_y     = w ? alu_ref(f, req_a[63:32], req_b[63:32]) : alu_ref(f, req_a[31:0], req_b[31:0]);
      m_ychk  = (f != 3'd3);
      m_id    = w;
      m_last  = w;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
  end

  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_f = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) at_pos();
    at_neg();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_y", rsp_y, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    // Single ADD from requester 0 right after reset release.
    at_pos();
    rst_n = 1'b1; req_valid = 2'b01; req_f = 6'o02; req_a = 64'd5; req_b = 64'd7;
    at_neg(); chk("add_ready", 32'(req_ready), 32'd1);
    at_pos(); req_valid = 2'b00;
    at_neg();
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_y", rsp_y, 32'd12);
    chk("add_z", 32'(rsp_z), 32'd0);
    chk("add_id", 32'(rsp_id), 32'd0);

    // SUB to zero then SLT from requester 1.
    at_pos();
    req_valid = 2'b10; req_f = 6'o60; req_a = {32'h1234, 32'h0}; req_b = {32'h1234, 32'h0};
    at_neg(); chk("sub_ready", 32'(req_ready), 32'd2);
    at_pos();
    req_f = 6'o70; req_a = {32'hFFFF_FFFF, 32'h0}; req_b = {32'h1, 32'h0};
    at_neg();
    chk("sub_y", rsp_y, 32'd0);
    chk("sub_z", 32'(rsp_z), 32'd1);
    chk("sub_id", 32'(rsp_id), 32'd1);
    at_pos(); req_valid = 2'b00;
    at_neg(); chk("slt_y", rsp_y, 32'd1);

    // Round-robin with both requesters always valid.
    at_pos();
    req_valid = 2'b11; req_f = 6'o22; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      if (i > 0) begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'((i - 1) % 2));
      end
      at_pos();
    end
    at_neg(); chk("rr_id_last", 32'(rsp_id), 32'd1);

    // Backpressure: hold 0xA for three cycles, then drain and refill together.
    at_pos();
    req_valid = 2'b01; req_f = 6'o02; req_a = 64'd4; req_b = 64'd6;
    at_neg(); chk("bp_fill", 32'(req_ready), 32'd1);
    at_pos(); req_valid = 2'b11; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_y", rsp_y, 32'hA);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      at_pos();
    end
    rsp_ready = 1'b1;
    at_neg();
    chk("bp_release", 32'(req_ready), 32'd2);
    chk("bp_y_rel", rsp_y, 32'hA);
    at_pos(); req_valid = 2'b00;
    at_neg(); chk("bp_id", 32'(rsp_id), 32'd1);

    // Wrap-around of ADD and SUB.
    at_pos();
    req_valid = 2'b01; req_f = 6'o02; req_a = {32'h0, 32'hFFFF_FFFF}; req_b = 64'd1;
    at_pos(); req_f = 6'o06; req_a = 64'd0; req_b = 64'd1;
    at_neg();
    chk("wrap_add_y", rsp_y, 32'd0);
    chk("wrap_add_z", 32'(rsp_z), 32'd1);
    at_pos(); req_valid = 2'b00;
    at_neg();
    chk("wrap_sub_y", rsp_y, 32'hFFFF_FFFF);
    chk("wrap_sub_z", 32'(rsp_z), 32'd0);

    // Reset while holding a result.
    at_pos();
    req_valid = 2'b01; req_f = 6'o02; req_a = 64'd3; req_b = 64'd4;
    at_pos(); req_valid = 2'b11; rsp_ready = 1'b0;
    at_neg(); chk("rh_y", rsp_y, 32'd7);
    at_pos(); rst_n = 1'b0;
    at_neg();
    chk("rh_ready", 32'(req_ready), 32'd0);
    chk("rh_held", 32'(rsp_valid), 32'd1);
    at_pos(); rst_n = 1'b1;
    at_neg();
    chk("rh_valid", 32'(rsp_valid), 32'd0);
    chk("rh_yz", rsp_y, 32'd0);
    chk("rh_id", 32'(rsp_id), 32'd0);
    chk("rh_tie", 32'(req_ready), 32'd1);

    // Randomized traffic, checked by the model on every cycle.
    for (int i = 0; i < 3000; i++) begin
      at_pos();
      rst_n     = ($urandom_range(63) != 0);
      req_valid = 2'($urandom);
      req_f     = 6'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      if ($urandom_range(3) == 0) req_b = req_a;
      if ($urandom_range(7) == 0) req_a[31:0] = 32'hFFFF_FFFF;
      rsp_ready = ($urandom_range(3) != 0);
    end
    at_pos();
    req_valid = 2'b00;
    at_neg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port: req_valid  input  2  request valid, bit n = requester n.
REQ-005 Port: req_ready  output  2  request accepted this cycle, bit n = requester n, at most one bit high.
REQ-006 Port: req_f  input  6  ALU opcode per requester, [2:0] = req 0, [5:3] = req 1.
REQ-007 Port: req_a  input  64  operand A per requester, [31:0] = req 0, [63:32] = req 1.
REQ-008 Port: req_b  input  64  operand B per requester, same packing as req_a.
REQ-009 Port: rsp_valid  output  1  registered result valid.
REQ-010 Port: rsp_ready  input  1  downstream consumes result when high with rsp_valid.
REQ-011 Port: rsp_y  output  32  registered ALU result.
REQ-012 Port: rsp_z  output  1  registered zero flag, 1 when rsp_y == 0.
REQ-013 Port: rsp_id  output  1  index of requester that owns rsp_y.

Function
REQ-014 The block SHALL share one combinational 32-bit ALU between two requesters; opcode set: 000 AND, 001 OR, 010 ADD, 100 A&~B, 101 A|~B, 110 SUB (A+~B+1), 111 SLT (result 1 if MSB of A-B is 1, else 0).
REQ-015 Opcode 011 SHALL be accepted and passed to the ALU unfiltered; its result is not checked.
REQ-016 ADD/SUB SHALL wrap modulo 2^32; carry-out is discarded.
REQ-017 State machine states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 The accept enable SHALL be high in EMPTY, or in FULL when rsp_ready=1 (drain and refill in the same cycle).
REQ-019 When accept enable is high and any req_valid bit is set, exactly one requester SHALL be granted: req_ready[n]=1 for winner n only.
REQ-020 req_ready SHALL be 0 for a requester whose req_valid is 0, and all bits SHALL be 0 when accept enable is low.
REQ-021 Arbitration SHALL be round-robin: one valid requester wins; if both are valid, the requester other than last_grant wins.
REQ-022 last_grant SHALL update to the winner only on an accept cycle.
REQ-023 On accept in cycle T, the ALU SHALL evaluate the winner's f/a/b in cycle T; rsp_y, rsp_z and rsp_id SHALL be registered and visible with rsp_valid=1 from cycle T+1 (latency 1).
REQ-024 Sustained throughput SHALL be one result per cycle while rsp_ready=1.
REQ-025 Transitions: EMPTY to FULL on accept; FULL to EMPTY on rsp_ready=1 with no accept; FULL stays FULL on rsp_ready=1 with accept; FULL stays FULL on rsp_ready=0 (hold).
REQ-026 In FULL with rsp_ready=0, rsp_y, rsp_z and rsp_id SHALL remain stable until consumed.
REQ-027 Requester inputs SHALL be sampled only in the accept cycle; later changes SHALL NOT affect the outstanding result.
REQ-028 rsp_y, rsp_z and rsp_id SHALL change only on accept cycles.
REQ-029 No combinational path SHALL exist from req_* to rsp_*.
REQ-030 req_ready MAY depend combinationally on req_valid and rsp_ready.

Reset
REQ-031 While rst_n=0 at a rising edge, the block SHALL set: state EMPTY, rsp_valid=0, rsp_y=0, rsp_z=0, rsp_id=0, last_grant=1 (requester 0 wins the first tie).
REQ-032 While rst_n=0, req_ready SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard any held result without delivering it.
REQ-034 The first accept SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-035 Single op: req 0 only, f=010, a=5, b=7, rsp_ready=1 -> req_ready=01 in T; at T+1: rsp_valid=1, rsp_y=12, rsp_z=0, rsp_id=0.
REQ-036 SUB zero and SLT: req 1, f=110, a=b=0x1234 -> rsp_y=0, rsp_z=1, rsp_id=1; then f=111, a=0xFFFFFFFF, b=1 -> rsp_y=1.
REQ-037 Round-robin: after reset, both valid every cycle with rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later; no bubbles.
REQ-038 Backpressure: FULL with rsp_y=0xA, rsp_ready=0 for 3 cycles with both valid -> req_ready=00 and rsp_* stable for 3 cycles; rsp_ready=1 -> drain and accept in the same cycle.
REQ-039 Wrap: f=010, a=0xFFFFFFFF, b=1 -> rsp_y=0, rsp_z=1; f=110, a=0, b=1 -> rsp_y=0xFFFFFFFF.
REQ-040 Reset mid-hold: FULL with rsp_ready=0, then rst_n=0 for 1 cycle -> rsp_valid=0, rsp_y=0, rsp_id=0; the next tie grants requester 0.
